// File: rtl/hazard_ctrl_pkg.sv
// Shared core types for the hazard controller and the execute-stage operand muxes.
// Holds the forward-select encodings and the per-stage tracking record.
// No logic lives here apart from one small stage-advance helper.
package hazard_ctrl_pkg;

  // Operand source select used by the execute stage bypass muxes.
  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,  // register file
    FWD_M2E  = 2'b01,  // M-stage ALU result
    FWD_W2E  = 2'b10   // writeback data
  } fwd_sel_e;

  // Per-stage record of what the datapath holds in that pipeline register.
  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       reg_write;
    logic       mem_read;
    logic       multicycle;
  } stage_t;

  localparam stage_t STAGE_BUBBLE = '0;

  // Source indices only matter in E; drop them once an op leaves E.
  function automatic stage_t leave_execute(input stage_t s);
    stage_t r;
    r     = s;
    r.rs1 = '0;
    r.rs2 = '0;
    return r;
  endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// Bypass select for one execute-stage source operand.
// Purely combinational; M-stage result wins over W, x0 never bypassed.
// Never produces code 11.
module fwd_sel
  import hazard_ctrl_pkg::*;
(
  input  logic [4:0] rs,
  input  logic [4:0] rd_M,
  input  logic       reg_write_M,
  input  logic [4:0] rd_W,
  input  logic       reg_write_W,
  output logic [1:0] sel
);

  // Pick the youngest in-flight producer of rs, ignoring writes to x0.
  always_comb begin
    sel = FWD_NONE;
    if (reg_write_M && (rd_M != 5'd0) && (rd_M == rs)) begin
      sel = FWD_M2E;
    end else if (reg_write_W && (rd_W != 5'd0) && (rd_W == rs)) begin
      sel = FWD_W2E;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, load-use stall, multi-cycle
// E-stage hold and taken-branch flush. Outputs are combinational from tracked
// state and decode inputs; priority is branch flush > multi-cycle hold > load-use.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MC_LAT = 4  // total E cycles of a MUL/DIV, 2..15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] rs1_D,
  input  logic [4:0] rs2_D,
  input  logic [4:0] rd_D,
  input  logic       reg_write_D,
  input  logic       mem_read_D,
  input  logic       multicycle_D,
  input  logic       branch_taken_E,
  output logic [1:0] forward_A_E,
  output logic [1:0] forward_B_E,
  output logic       stall_F,
  output logic       stall_D,
  output logic       stall_E,
  output logic       flush_D,
  output logic       flush_E,
  output logic       mc_busy
);

  localparam logic [3:0] MC_LOAD = 4'(MC_LAT - 1);

  stage_t     e_q, e_d;
  stage_t     m_q, m_d;
  stage_t     w_q, w_d;
  logic [3:0] mc_cnt_q, mc_cnt_d;
  logic       mc_run_q, mc_run_d;   // current E op already started its count

  stage_t     dec;
  logic       mc_first;
  logic [3:0] mc_cnt_eff;
  logic       busy;
  logic       load_use;
  logic       lu_act;

  // M/W carry the full record for visibility; hazard logic only needs rd/reg_write there.
  logic unused_stage_bits;
  assign unused_stage_bits = ^{m_q.rs1, m_q.rs2, m_q.mem_read, m_q.multicycle,
                               w_q.rs1, w_q.rs2, w_q.mem_read, w_q.multicycle};

  // Hazard detection and control outputs.
  always_comb begin
    dec.rs1        = rs1_D;
    dec.rs2        = rs2_D;
    dec.rd         = rd_D;
    dec.reg_write  = reg_write_D;
    dec.mem_read   = mem_read_D;
    dec.multicycle = multicycle_D;

    // On its first E cycle the counter value is taken as the load value, so
    // the hold starts immediately and E occupancy totals MC_LAT cycles.
    mc_first   = e_q.multicycle && !mc_run_q;
    mc_cnt_eff = mc_first ? MC_LOAD : mc_cnt_q;
    busy       = (mc_cnt_eff != 4'd0);

    load_use = e_q.mem_read && (e_q.rd != 5'd0) &&
               ((e_q.rd == rs1_D) || (e_q.rd == rs2_D));
    lu_act   = load_use && !busy && !branch_taken_E;

    mc_busy = busy;
    flush_D = branch_taken_E;
    flush_E = branch_taken_E || lu_act;
    stall_F = !branch_taken_E && (busy || lu_act);
    stall_D = !branch_taken_E && (busy || lu_act);
    stall_E = !branch_taken_E && busy;
  end

  // Advance the tracking registers exactly as the datapath registers move.
  always_comb begin
    e_d      = dec;
    m_d      = leave_execute(e_q);
    w_d      = m_q;
    mc_cnt_d = 4'd0;
    mc_run_d = 1'b0;
    if (branch_taken_E) begin
      e_d = STAGE_BUBBLE;
    end else if (busy) begin
      e_d      = e_q;
      m_d      = STAGE_BUBBLE;
      mc_cnt_d = mc_cnt_eff - 4'd1;
      mc_run_d = 1'b1;
    end else if (lu_act) begin
      e_d = STAGE_BUBBLE;
    end
  end

  // State registers; reset empties the pipe and aborts any multi-cycle op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_q      <= STAGE_BUBBLE;
      m_q      <= STAGE_BUBBLE;
      w_q      <= STAGE_BUBBLE;
      mc_cnt_q <= 4'd0;
      mc_run_q <= 1'b0;
    end else begin
      e_q      <= e_d;
      m_q      <= m_d;
      w_q      <= w_d;
      mc_cnt_q <= mc_cnt_d;
      mc_run_q <= mc_run_d;
    end
  end

  fwd_sel u_fwd_a (
    .rs          (e_q.rs1),
    .rd_M        (m_q.rd),
    .reg_write_M (m_q.reg_write),
    .rd_W        (w_q.rd),
    .reg_write_W (w_q.reg_write),
    .sel         (forward_A_E)
  );

  fwd_sel u_fwd_b (
    .rs          (e_q.rs2),
    .rd_M        (m_q.rd),
    .reg_write_M (m_q.reg_write),
    .rd_W        (w_q.rd),
    .reg_write_W (w_q.reg_write),
    .sel         (forward_B_E)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl: directed scenarios plus randomized traffic
// checked against an instruction-level pipeline model.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_hazard_ctrl;

  localparam int MC_LAT = 4;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       rw;
    logic       mr;
    logic       mc;
  } ins_t;

  localparam ins_t NOP = '0;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] rs1_D, rs2_D, rd_D;
  logic       reg_write_D, mem_read_D, multicycle_D, branch_taken_E;
  logic [1:0] forward_A_E, forward_B_E;
  logic       stall_F, stall_D, stall_E, flush_D, flush_E, mc_busy;

  always #5 clk = ~clk;

  hazard_ctrl #(.MC_LAT(MC_LAT)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rs1_D          (rs1_D),
    .rs2_D          (rs2_D),
    .rd_D           (rd_D),
    .reg_write_D    (reg_write_D),
    .mem_read_D     (mem_read_D),
    .multicycle_D   (multicycle_D),
    .branch_taken_E (branch_taken_E),
    .forward_A_E    (forward_A_E),
    .forward_B_E    (forward_B_E),
    .stall_F        (stall_F),
    .stall_D        (stall_D),
    .stall_E        (stall_E),
    .flush_D        (flush_D),
    .flush_E        (flush_E),
    .mc_busy        (mc_busy)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: which instruction sits in E/M/W and how long E's has been there.
  ins_t me, mm, mw;
  int   age;
  ins_t d_cur;
  logic br_cur;

  logic [10:0] got_v;
  logic [4:0]  ctl_v;
  assign got_v = {forward_A_E, forward_B_E, stall_F, stall_D, stall_E, flush_D, flush_E, mc_busy};
  assign ctl_v = {stall_F, stall_D, stall_E, flush_D, flush_E};

  function automatic ins_t mk(input int rs1, input int rs2, input int rd,
                              input bit rw, input bit mr, input bit mc);
    ins_t r;
    r.rs1 = 5'(rs1); r.rs2 = 5'(rs2); r.rd = 5'(rd);
    r.rw = rw; r.mr = mr; r.mc = mc;
    return r;
  endfunction

  function automatic logic [1:0] src_of(input logic [4:0] rs);
    if (mm.rw && mm.rd != 0 && mm.rd == rs) return 2'b01;
    if (mw.rw && mw.rd != 0 && mw.rd == rs) return 2'b10;
    return 2'b00;
  endfunction

  function automatic bit m_busy();
    return me.mc && (age < MC_LAT - 1);
  endfunction

  function automatic bit m_loaduse();
    return me.mr && me.rd != 0 && (me.rd == d_cur.rs1 || me.rd == d_cur.rs2);
  endfunction

  function automatic logic [10:0] model_out();
    logic sf, sd, se, fd, fe;
    sf = 0; sd = 0; se = 0; fd = 0; fe = 0;
    if (br_cur) begin
      fd = 1; fe = 1;
    end else if (m_busy()) begin
      sf = 1; sd = 1; se = 1;
    end else if (m_loaduse()) begin
      sf = 1; sd = 1; fe = 1;
    end
    return {src_of(me.rs1), src_of(me.rs2), sf, sd, se, fd, fe, m_busy()};
  endfunction

  task automatic model_step();
    mw = mm;
    if (br_cur) begin
      mm = me; me = NOP; age = 0;
    end else if (m_busy()) begin
      mm = NOP; age = age + 1;
    end else if (m_loaduse()) begin
      mm = me; me = NOP; age = 0;
    end else begin
      mm = me; me = d_cur; age = 0;
    end
  endtask

  task automatic drive(input ins_t d, input logic br);
    d_cur = d; br_cur = br;
    rs1_D = d.rs1; rs2_D = d.rs2; rd_D = d.rd;
    reg_write_D = d.rw; mem_read_D = d.mr; multicycle_D = d.mc;
    branch_taken_E = br;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    me = NOP; mm = NOP; mw = NOP; age = 0;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    drive(NOP, 1'b0);
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(mk(3, 3, 3, 1, 1, 1), 1'b0);
    model_clear();
    #3;
    checks++;
    if (got_v !== 11'd0) begin
      failures++; $display("FAIL reset_during got=%b exp=%b", got_v, 11'd0);
    end
    @(posedge clk); #1;
    drive(NOP, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (got_v !== 11'd0) begin
      failures++; $display("FAIL reset_after got=%b exp=%b", got_v, 11'd0);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_forward();
    reset_dut();
    drive(mk(1, 2, 5, 1, 0, 0), 0); tick();
    drive(mk(5, 2, 5, 1, 0, 0), 0); tick();
    drive(mk(5, 6, 5, 1, 0, 0), 0);
    @(negedge clk);
    checks++;
    if (forward_A_E !== 2'b01) begin
      failures++; $display("FAIL fwd_m_only got=%b exp=01", forward_A_E);
    end
    tick();
    drive(mk(1, 1, 0, 1, 0, 0), 0);
    @(negedge clk);
    checks++;
    if (forward_A_E !== 2'b01) begin
      failures++; $display("FAIL fwd_m_over_w got=%b exp=01", forward_A_E);
    end
    tick();
    drive(mk(3, 0, 4, 1, 0, 0), 0); tick();
    drive(NOP, 0);
    @(negedge clk);
    checks++;
    if ({forward_A_E, forward_B_E} !== 4'b0000) begin
      failures++; $display("FAIL fwd_x0 got=%b exp=0000", {forward_A_E, forward_B_E});
    end
    tick();
  endtask

  task automatic test_load_use();
    reset_dut();
    drive(mk(1, 2, 7, 1, 1, 0), 0); tick();
    drive(mk(1, 7, 8, 1, 0, 0), 0);
    @(negedge clk);
    checks++;
    if (ctl_v !== 5'b11001) begin
      failures++; $display("FAIL loaduse_stall got=%b exp=11001", ctl_v);
    end
    tick();
    @(negedge clk);
    checks++;
    if (ctl_v !== 5'b00000) begin
      failures++; $display("FAIL loaduse_once got=%b exp=00000", ctl_v);
    end
    tick();
    drive(NOP, 0);
    @(negedge clk);
    checks++;
    if (forward_B_E !== 2'b10) begin
      failures++; $display("FAIL loaduse_fwd_w got=%b exp=10", forward_B_E);
    end
    tick();
  endtask

  task automatic test_multicycle();
    logic [1:0] exp_fa [0:2];
    exp_fa[0] = 2'b01; exp_fa[1] = 2'b10; exp_fa[2] = 2'b00;
    reset_dut();
    drive(mk(0, 0, 3, 1, 0, 0), 0); tick();
    drive(mk(3, 4, 9, 1, 0, 1), 0); tick();
    drive(mk(9, 0, 10, 1, 0, 0), 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if ({mc_busy, stall_E, stall_F, forward_A_E} !== {3'b111, exp_fa[c]}) begin
        failures++;
        $display("FAIL mc_busy_cyc%0d got=%b exp=%b", c,
                 {mc_busy, stall_E, stall_F, forward_A_E}, {3'b111, exp_fa[c]});
      end
      tick();
    end
    @(negedge clk);
    checks++;
    if ({mc_busy, stall_E, stall_F} !== 3'b000) begin
      failures++; $display("FAIL mc_release got=%b exp=000", {mc_busy, stall_E, stall_F});
    end
    tick();
    @(negedge clk);
    checks++;
    if (forward_A_E !== 2'b01) begin
      failures++; $display("FAIL mc_reached_m got=%b exp=01", forward_A_E);
    end
    tick();
  endtask

  task automatic test_branch();
    reset_dut();
    drive(mk(1, 2, 7, 1, 1, 0), 0); tick();
    drive(mk(7, 1, 8, 1, 0, 0), 1);
    @(negedge clk);
    checks++;
    if ({ctl_v, mc_busy} !== 6'b000110) begin
      failures++; $display("FAIL branch_flush got=%b exp=000110", {ctl_v, mc_busy});
    end
    tick();
    drive(NOP, 0);
    @(negedge clk);
    checks++;
    if (ctl_v !== 5'b00000) begin
      failures++; $display("FAIL branch_after got=%b exp=00000", ctl_v);
    end
    tick();
  endtask

  task automatic test_reset_mid_mc();
    reset_dut();
    drive(mk(1, 2, 9, 1, 0, 1), 0); tick();
    drive(NOP, 0);
    tick();
    #2;
    checks++;
    if (mc_busy !== 1'b1) begin
      failures++; $display("FAIL mc_second_cycle got=%b exp=1", mc_busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (got_v !== 11'd0) begin
      failures++; $display("FAIL mc_async_abort got=%b exp=%b", got_v, 11'd0);
    end
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (got_v !== 11'd0) begin
      failures++; $display("FAIL mc_abort_release got=%b exp=%b", got_v, 11'd0);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (got_v !== 11'd0) begin
      failures++; $display("FAIL mc_no_residual got=%b exp=%b", got_v, 11'd0);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    ins_t        d;
    logic        br;
    logic [10:0] exp_v;
    bit          hold;
    int          r;
    reset_dut();
    d = NOP; hold = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (!hold) begin
        r = $urandom_range(0, 99);
        d.rs1 = 5'($urandom_range(0, 7));
        d.rs2 = 5'($urandom_range(0, 7));
        d.rd  = 5'($urandom_range(0, 7));
        d.rw  = ($urandom_range(0, 9) < 7);
        d.mr  = (r < 25);
        d.mc  = (r >= 88);
      end
      br = ($urandom_range(0, 9) == 0) && !me.mc;
      drive(d, br);
      exp_v = model_out();
      @(negedge clk);
      checks++;
      if (got_v !== exp_v) begin
        failures++; $display("FAIL random cyc=%0d got=%b exp=%b", cyc, got_v, exp_v);
      end
      hold = exp_v[6] && !br;
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    drive(NOP, 1'b0);
    model_clear();
    test_reset();
    test_forward();
    test_load_use();
    test_multicycle();
    test_branch();
    test_reset_mid_mc();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter MC_LAT, default 4, meaning the total execute-stage cycles of a multi-cycle (MUL/DIV) op, legal range 2..15.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports rs1_D, rs2_D, rd_D  input  5 each  decode-stage source and destination register indices.
REQ-005 SHALL have ports reg_write_D, mem_read_D, multicycle_D  input  1 each  decode-stage op writes rd / is a load / is a multi-cycle op.
REQ-006 SHALL have port branch_taken_E  input  1  branch or jump in E resolved taken this cycle.
REQ-007 SHALL have ports forward_A_E, forward_B_E  output  2 each  operand select for the execute stage: 00 = register file, 01 = M-stage ALU result, 10 = writeback data.
REQ-008 SHALL have ports stall_F, stall_D, stall_E  output  1 each  hold the PC, IF/ID register and ID/EX register respectively.
REQ-009 SHALL have ports flush_D, flush_E  output  1 each  clear IF/ID / ID/EX to a bubble at the next edge.
REQ-010 SHALL have port mc_busy  output  1  a multi-cycle op is occupying E.

Function
REQ-011 SHALL track the E, M and W stages internally; each stage holds rs1, rs2, rd, reg_write, mem_read and multicycle (rs1/rs2 are needed in E only).
REQ-012 SHALL advance the tracking registers with the same stall and flush it drives, so the internal view always matches the datapath.
REQ-013 SHALL drive forward_A_E = 01 when reg_write_M=1, rd_M≠0 and rd_M=rs1_E.
REQ-014 Otherwise, SHALL drive forward_A_E = 10 when reg_write_W=1, rd_W≠0 and rd_W=rs1_E; otherwise 00.
REQ-015 SHALL compute forward_B_E identically against rs2_E; M has priority over W, x0 is never forwarded, and code 11 is never produced.
REQ-016 SHALL detect a load-use hazard: mem_read_E=1, rd_E≠0, and rd_E equal to rs1_D or rs2_D.
REQ-017 On a load-use hazard, SHALL assert stall_F, stall_D and flush_E for exactly one cycle.
REQ-018 SHALL hold a 4-bit down-counter mc_cnt; it loads MC_LAT-1 on the first cycle an op with multicycle_E=1 is in E.
REQ-019 While mc_cnt≠0, SHALL assert mc_busy, stall_F, stall_D and stall_E, decrement mc_cnt each cycle, and present a bubble to M.
REQ-020 The multi-cycle op SHALL advance to M when mc_cnt reaches 0; total E occupancy is MC_LAT cycles.
REQ-021 On branch_taken_E=1, SHALL assert flush_D and flush_E for one cycle, and SHALL assert no stall that cycle; branch flush has priority over load-use.
REQ-022 A load-use condition coincident with a taken branch SHALL be discarded.
REQ-023 The multi-cycle stall has priority over load-use detection; load-use SHALL be re-evaluated when the stall releases.
REQ-024 Forwarding outputs SHALL remain valid during a multi-cycle stall, so operands stay stable while E is held.
REQ-025 All outputs other than the internal registers SHALL be combinational from current state and inputs; the only added latency is the one-cycle bubble.

Reset
REQ-026 While rst_n=0, SHALL clear all tracking registers to bubbles (reg_write=0, mem_read=0, multicycle=0, indices 0) and set mc_cnt=0.
REQ-027 Consequently, all outputs SHALL read 0 during and immediately after reset.
REQ-028 Reset asserted mid multi-cycle op SHALL abort the op immediately; after release, no residual stall SHALL be asserted.

Structure
REQ-029 SHALL place the forward-select encodings (FWD_NONE=00, FWD_M2E=01, FWD_W2E=10) in the shared core package; the execute stage uses the same encodings.
REQ-030 SHALL instantiate one sub-module, fwd_sel, instanced twice (A and B): inputs rs, rd_M, reg_write_M, rd_W, reg_write_W; output 2-bit select.

Verification
REQ-031 Scenario: add x5 in M, x5=rs1 in E, reg_write_M=1 -> forward_A_E=01; same rd also in W -> still 01.
REQ-032 Scenario: rd_M=0 with reg_write_M=1 and rs2_E=0 -> forward_B_E=00.
REQ-033 Scenario: load x7 in E, decode rs2_D=7 -> one cycle of stall_F=stall_D=flush_E=1; next cycle forward_B_E=10 from W.
REQ-034 Scenario: MUL in E with MC_LAT=4 -> mc_busy and stall_E high for 3 cycles; bubbles enter M; MUL reaches M on the 4th edge.
REQ-035 Scenario: taken branch in E while decode holds a load-use dependent -> flush_D=flush_E=1, stall_F=0.
REQ-036 Scenario: rst_n pulsed low on the 2nd busy cycle -> mc_busy=0 asynchronously; all outputs 0 after release.
